// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer / deserializer pair.
// Holds the Hamming sizing helpers, the data-bit position map and the
// transmit FSM state encoding.
//   code_bits(dw)   : number of Hamming check bits r, smallest with 2^r >= dw + r + 1
//   coded_width(dw) : dw + code_bits(dw)
//   data_pos(idx)   : 1-based Hamming position of data bit idx (powers of two are check slots)
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_e;

  function automatic int code_bits(input int dw);
    int r;
    r = 0;
    while ((1 << r) < (dw + r + 1)) r++;
    return r;
  endfunction

  function automatic int coded_width(input int dw);
    return dw + code_bits(dw);
  endfunction

  // Walk positions 3,5,6,7,9,... skipping powers of two until the
  // idx-th data slot is reached.
  function automatic int data_pos(input int idx);
    int pos;
    int n;
    pos = 3;
    n   = 0;
    while ((n < idx) || ((pos & (pos - 1)) == 0)) begin
      if ((pos & (pos - 1)) != 0) n++;
      pos++;
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_encode.sv
// Combinational Hamming encoder.
// Check bit j is the parity of every data bit whose Hamming position has bit j
// set, so a receiver can compute the syndrome directly as the failing position.
// Ports:
//   data_i  in   DATA_WIDTH              payload
//   code_o  out  coded_width(DATA_WIDTH) {data_i, check}
module hamming_encode
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]              data_i,
  output logic [coded_width(DATA_WIDTH)-1:0] code_o
);

  localparam int CB = code_bits(DATA_WIDTH);

  logic [CB-1:0] w_check;

  always_comb begin
    w_check = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      for (int j = 0; j < CB; j++) begin
        if (((data_pos(i) >> j) & 1) != 0) w_check[j] = w_check[j] ^ data_i[i];
      end
    end
  end

  assign code_o = {data_i, w_check};

endmodule

// File: rtl/serializer.sv
// Transmit-side serializer: one-entry holding register on a valid/ready
// handshake, optional Hamming encode before the holding register, and an
// MSB-first shifter paced by an external bit tick with enable/start/done framing.
// Ports:
//   clk_i         in   clock
//   rst_i         in   synchronous reset, active-high
//   data_i        in   parallel payload (DATA_WIDTH)
//   valid_i       in   data_i valid
//   ready_o       out  holding register empty
//   bit_tick_i    in   bit-rate strobe, one serial bit per tick
//   serial_out_o  out  serial data, frame MSB first
//   enable_o      out  serial_out_o carries a bit this cycle
//   start_o       out  first bit of a frame
//   busy_o        out  FSM not IDLE or holding register occupied
//   done_o        out  last bit of a frame
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HAS_ECC    = 0,
  parameter int GAP_BITS   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  bit_tick_i,
  output logic                  serial_out_o,
  output logic                  enable_o,
  output logic                  start_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int FRAME_WIDTH = (HAS_ECC != 0) ? coded_width(DATA_WIDTH) : DATA_WIDTH;
  localparam int CNT_W       = $clog2(FRAME_WIDTH + 1);
  localparam int GAP_W       = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  logic [FRAME_WIDTH-1:0] w_frame;

  generate
    if (HAS_ECC != 0) begin : g_ecc
      hamming_encode #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
        .data_i (data_i),
        .code_o (w_frame)
      );
    end else begin : g_raw
      assign w_frame = data_i;
    end
  endgenerate

  ser_state_e             r_state, w_state_nxt;
  logic                   r_hold_full, w_hold_full_nxt;
  logic [FRAME_WIDTH-1:0] r_hold, w_hold_nxt;
  logic [FRAME_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_rem;
  logic [GAP_W-1:0]       r_gap_cnt, w_gap_cnt_nxt;
  logic                   w_accept, w_drain, w_emit, w_bit, w_first, w_last;
  logic                   r_serial, r_enable, r_start, r_done;

  // w_rem is the number of frame bits still to send, counting the one
  // emitted this tick; it equals FRAME_WIDTH on a frame's first bit.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    w_accept      = valid_i && !r_hold_full;
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_drain       = 1'b0;
    w_emit        = 1'b0;
    w_bit         = 1'b0;
    w_rem         = '0;

    case (r_state)
      IDLE: begin
        if (bit_tick_i && r_hold_full) begin
          w_drain     = 1'b1;
          w_emit      = 1'b1;
          w_bit       = r_hold[FRAME_WIDTH-1];
          w_rem       = CNT_FULL;
          w_shift_nxt = r_hold << 1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_tick_i) begin
          w_emit      = 1'b1;
          w_bit       = r_shift[FRAME_WIDTH-1];
          w_rem       = r_cnt;
          w_shift_nxt = r_shift << 1;
        end
      end
      GAP: begin
        if (bit_tick_i) begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt   = IDLE;
            w_gap_cnt_nxt = '0;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_emit) begin
      w_cnt_nxt = w_rem - CNT_ONE;
      if (w_rem == CNT_ONE) begin
        if (GAP_BITS > 0) begin
          w_state_nxt   = GAP;
          w_gap_cnt_nxt = '0;
        end else if (r_hold_full && !w_drain) begin
          // Gapless reload: the next tick sends the new frame's MSB from SHIFT.
          w_drain     = 1'b1;
          w_shift_nxt = r_hold;
          w_cnt_nxt   = CNT_FULL;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    end

    w_first         = w_emit && (w_rem == CNT_FULL);
    w_last          = w_emit && (w_rem == CNT_ONE);
    w_hold_full_nxt = (r_hold_full && !w_drain) || w_accept;
    w_hold_nxt      = w_accept ? w_frame : r_hold;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state     <= IDLE;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
      r_serial    <= 1'b0;
      r_enable    <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_hold      <= w_hold_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_serial    <= w_emit && w_bit;
      r_enable    <= w_emit;
      r_start     <= w_first;
      r_done      <= w_last;
    end
  end

  assign ready_o      = !r_hold_full;
  assign busy_o       = (r_state != IDLE) || r_hold_full;
  assign serial_out_o = r_serial;
  assign enable_o     = r_enable;
  assign start_o      = r_start;
  assign done_o       = r_done;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer. Three instances: raw back-to-back,
// raw with a 2-tick gap, and Hamming-encoded. A monitor acts as the receiving
// deserializer: it collects each frame between start_o and done_o and compares
// it with the scoreboard entry pushed when the word was accepted.
module tb_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] data;
  logic [2:0] valid, ready, ser, en, st, busy, dn;

  int total = 0;
  int bad   = 0;

  // Raw instances: {8'h0, frame}. ECC instance: {7'h0, expected_errors, data}.
  logic [15:0] exp_q[$];
  int          pos_of[12];
  int          inject_bit  = -1;
  int          tick_period = 1;
  int          tick_cnt    = 0;
  logic [15:0] acc [3];
  int          nb  [3];
  logic [15:0] mon_e;
  logic [8:0]  mon_dec;
  int          gap_n;

  always #5 clk = ~clk;

  serializer #(.DATA_WIDTH(8), .HAS_ECC(0), .GAP_BITS(0)) u_raw (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid[0]), .ready_o(ready[0]),
    .bit_tick_i(tick), .serial_out_o(ser[0]), .enable_o(en[0]), .start_o(st[0]),
    .busy_o(busy[0]), .done_o(dn[0])
  );

  serializer #(.DATA_WIDTH(8), .HAS_ECC(0), .GAP_BITS(2)) u_gap (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid[1]), .ready_o(ready[1]),
    .bit_tick_i(tick), .serial_out_o(ser[1]), .enable_o(en[1]), .start_o(st[1]),
    .busy_o(busy[1]), .done_o(dn[1])
  );

  serializer #(.DATA_WIDTH(8), .HAS_ECC(1), .GAP_BITS(0)) u_ecc (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid[2]), .ready_o(ready[2]),
    .bit_tick_i(tick), .serial_out_o(ser[2]), .enable_o(en[2]), .start_o(st[2]),
    .busy_o(busy[2]), .done_o(dn[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Receiver-side Hamming decode: syndrome = XOR of positions of set bits.
  function automatic logic [8:0] ecc_decode(input logic [11:0] f);
    int          syn = 0;
    logic [11:0] g   = f;
    for (int k = 0; k < 12; k++) if (g[k]) syn = syn ^ pos_of[k];
    if (syn != 0) begin
      for (int k = 0; k < 12; k++) if (pos_of[k] == syn) g[k] = ~g[k];
    end
    return {syn != 0, g[11:4]};
  endfunction

  // Bit tick generator: every cycle, or every tick_period cycles.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      tick = (tick_period <= 1) || ((tick_cnt % tick_period) == 0);
    end
  end

  // Deserializer model / scoreboard consumer.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) nb[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (en[i]) begin
          if (st[i]) begin
            check($sformatf("start_pos%0d", i), nb[i], 0);
            acc[i] = '0;
            nb[i]  = 0;
          end
          acc[i] = {acc[i][14:0], ser[i]};
          nb[i]++;
          if (dn[i]) begin
            if (exp_q.size() == 0) begin
              check($sformatf("unexpected_done%0d", i), 1, 0);
            end else begin
              mon_e = exp_q.pop_front();
              if (i == 2) begin
                if (inject_bit >= 0) acc[2] = acc[2] ^ (16'd1 << inject_bit);
                mon_dec = ecc_decode(acc[2][11:0]);
                check("ecc_data", mon_dec[7:0], mon_e[7:0]);
                check("ecc_errs", mon_dec[8], mon_e[8]);
                check("ecc_len", nb[i], 12);
              end else begin
                check($sformatf("frame%0d", i), acc[i][7:0], mon_e[7:0]);
                check($sformatf("frame_len%0d", i), nb[i], 8);
              end
            end
            nb[i] = 0;
          end
        end else if (st[i] || dn[i] || ser[i]) begin
          check($sformatf("quiet_when_idle%0d", i), {st[i], dn[i], ser[i]}, 0);
        end
      end
    end
  end

  task automatic send(input int inst, input logic [7:0] d);
    int n = 0;
    data        = d;
    valid[inst] = 1'b1;
    while (!ready[inst] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", ready[inst], 1);
    @(posedge clk);
    exp_q.push_back((inst == 2) ? {7'd0, inject_bit >= 0, d} : {8'd0, d});
    #1;
    valid[inst] = 1'b0;
  endtask

  // Waits for enable_o, then checks nbits bits MSB-first with start/done
  // framing every fw bits and spacing cycles between consecutive bits.
  task automatic expect_bits(input int inst, input logic [15:0] val, input int nbits,
                             input int fw, input int spacing);
    int n = 0;
    while (!en[inst] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bits_wait_enable", en[inst], 1);
    if (!en[inst]) return;
    for (int k = 0; k < nbits; k++) begin
      check($sformatf("bit_en[%0d]", k), en[inst], 1);
      check($sformatf("bit_val[%0d]", k), ser[inst], val[nbits-1-k]);
      check($sformatf("bit_start[%0d]", k), st[inst], (k % fw) == 0);
      check($sformatf("bit_done[%0d]", k), dn[inst], (k % fw) == (fw - 1));
      if (k < nbits - 1) begin
        for (int s = 1; s < spacing; s++) begin
          @(negedge clk);
          check($sformatf("bit_spacing[%0d]", k), en[inst], 0);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic drain_wait();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p;
    int d;
    for (int j = 0; j < 4; j++) pos_of[j] = 1 << j;
    p = 1;
    d = 0;
    while (d < 8) begin
      if ((p & (p - 1)) != 0) begin
        pos_of[4 + d] = p;
        d++;
      end
      p++;
    end

    rst   = 1'b1;
    valid = '0;
    data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state of all instances.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready%0d", i), ready[i], 1);
      check($sformatf("rst_outs%0d", i), {ser[i], en[i], st[i], busy[i], dn[i]}, 0);
    end

    // Ticks while idle and empty do nothing.
    repeat (4) begin
      @(negedge clk);
      check("idle_tick", {en, busy, dn}, 0);
    end

    // 1: single word, tick every cycle, first bit two cycles after accept.
    send(0, 8'hA5);
    @(negedge clk);
    check("t1_latency_quiet", en[0], 0);
    @(negedge clk);
    check("t1_first_start", st[0], 1);
    expect_bits(0, 16'h00A5, 8, 8, 1);
    drain_wait();

    // 2: back-to-back words, gapless 16-bit stream.
    fork
      begin
        send(0, 8'h3C);
        send(0, 8'hC3);
      end
      expect_bits(0, 16'h3CC3, 16, 8, 1);
    join
    drain_wait();

    // 3: tick every 4 cycles; ready stays low until the load tick.
    tick_period = 4;
    send(0, 8'h81);
    gap_n = 0;
    while (!en[0] && gap_n < 20) begin
      check("t3_ready_low", ready[0], 0);
      @(negedge clk);
      gap_n++;
    end
    check("t3_ready_after_load", ready[0], 1);
    expect_bits(0, 16'h0081, 8, 8, 4);
    tick_period = 1;
    drain_wait();

    // 4: two idle ticks between frames.
    fork
      begin
        send(1, 8'h12);
        send(1, 8'h34);
      end
      begin
        expect_bits(1, 16'h0012, 8, 8, 1);
        @(negedge clk);
        gap_n = 0;
        while (!en[1] && gap_n < 20) begin
          gap_n++;
          @(negedge clk);
        end
        check("t4_gap_ticks", gap_n, 2);
        check("t4_second_start", st[1], 1);
        expect_bits(1, 16'h0034, 8, 8, 1);
      end
    join
    drain_wait();

    // 5: Hamming-encoded frames, clean and with one bit flipped in flight.
    fork
      send(2, 8'h5A);
      expect_bits(2, 16'h05A0, 12, 12, 1);
    join
    drain_wait();
    send(2, 8'hC7);
    send(2, 8'h01);
    drain_wait();
    inject_bit = 6;
    send(2, 8'h5A);
    drain_wait();
    inject_bit = 1;
    send(2, 8'hC7);
    drain_wait();
    inject_bit = -1;

    // 6: reset at bit 3 with a second word held.
    send(0, 8'hFF);
    send(0, 8'hAA);
    repeat (3) @(negedge clk);
    check("t6_bit3_en", en[0], 1);
    check("t6_hold_full", ready[0], 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outs", {ser[0], en[0], st[0], busy[0], dn[0]}, 0);
    check("t6_rst_ready", ready[0], 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("t6_quiet", {en[0], dn[0], busy[0]}, 0);
    end
    fork
      send(0, 8'h0F);
      expect_bits(0, 16'h000F, 8, 8, 1);
    join
    drain_wait();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
